// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  // Word offset within a 16-byte block and the block itself.
  localparam int OFFSET_BITS = 2;
  localparam int BLOCK_BITS  = 128;
  localparam int WORD_BITS   = 32;

  // Refill sequencer states.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } icache_state_t;

  // Tag width left over after byte offset, word offset and index.
  function automatic int tag_width(input int index_bits);
    return 32 - 2 - OFFSET_BITS - index_bits;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache. Reads are asynchronous by
// index so a hit can be served in the same cycle; writes land on the clock edge.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = tag_width(INDEX_BITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_reg;
  logic [LINES-1:0]      wr_sel;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [BLOCK_BITS-1:0] data_mem [LINES];

  // One-hot write decode, one bit per line.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_sel
      assign wr_sel[gi] = wr_en && (wr_index == INDEX_BITS'(gi));
    end
  endgenerate

  // Valid bits: cleared by reset, set when a line is refilled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_reg | wr_sel;
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, busy-wait block
// refill on a miss. Optional performance counters under ICACHE_PERF_CNT_EN.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  input  logic                  insReadEn,
  output logic [31:0]           INSTRUCTION,
  output logic                  INS_CACHE_BUSY_WAIT,
  output logic                  MEM_READ,
  output logic [27:0]           MEM_ADDR,
  input  logic [BLOCK_BITS-1:0] MEM_READ_DATA,
  input  logic                  MEM_BUSY_WAIT,
  output logic [31:0]           HIT_COUNT,
  output logic [31:0]           MISS_COUNT
);

  localparam int TAG_BITS = tag_width(INDEX_BITS);
  localparam int WORDS    = 1 << OFFSET_BITS;

  // Address fields; the byte offset is irrelevant for word fetches.
  logic [OFFSET_BITS-1:0] pc_offset;
  logic [INDEX_BITS-1:0]  pc_index;
  logic [TAG_BITS-1:0]    pc_tag;
  logic                   unused_pc_bits;

  assign pc_offset      = PC[3:2];
  assign pc_index       = PC[3+INDEX_BITS:4];
  assign pc_tag         = PC[31:4+INDEX_BITS];
  assign unused_pc_bits = ^PC[1:0];

  icache_state_t state_reg, state_next;

  logic [TAG_BITS-1:0]   tag_reg;
  logic [INDEX_BITS-1:0] index_reg;
  logic [BLOCK_BITS-1:0] block_reg;

  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [BLOCK_BITS-1:0] line_data;
  logic [WORD_BITS-1:0]  line_words [WORDS];
  logic                  hit;

  logic                  busy;
  logic [31:0]           instr;
  logic                  mem_read;
  logic [27:0]           mem_addr;
  logic                  wr_en;
  logic                  count_hit;
  logic                  count_miss;

  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clk      (CLK),
    .reset_n  (RESET),
    .rd_index (pc_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en && RESET),
    .wr_index (index_reg),
    .wr_tag   (tag_reg),
    .wr_data  (block_reg)
  );

  // Split the selected line into words for the offset mux.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign line_words[gi] = line_data[WORD_BITS*gi +: WORD_BITS];
    end
  endgenerate

  assign hit = insReadEn && line_valid && (line_tag == pc_tag);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the missing block's address on detection and its data on capture,
  // so the refill is independent of what the core does with PC meanwhile.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      tag_reg   <= '0;
      index_reg <= '0;
    end else if (state_reg == S_IDLE && insReadEn && !hit) begin
      tag_reg   <= pc_tag;
      index_reg <= pc_index;
    end
  end

  // Refill data capture when memory signals valid data.
  always_ff @(posedge CLK) begin
    if (state_reg == S_MEM_READ && !MEM_BUSY_WAIT) begin
      block_reg <= MEM_READ_DATA;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    instr      = '0;
    mem_read   = 1'b0;
    mem_addr   = '0;
    wr_en      = 1'b0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (hit) begin
          instr     = line_words[pc_offset];
          count_hit = 1'b1;
        end else if (insReadEn) begin
          busy       = 1'b1;
          count_miss = 1'b1;
          state_next = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = {tag_reg, index_reg};
        if (!MEM_BUSY_WAIT) begin
          state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Reset holds every core- and memory-facing output quiet, even mid-refill.
  assign INSTRUCTION         = RESET ? instr    : '0;
  assign INS_CACHE_BUSY_WAIT = RESET ? busy     : 1'b0;
  assign MEM_READ            = RESET ? mem_read : 1'b0;
  assign MEM_ADDR            = RESET ? mem_addr : '0;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;

  // Free-running hit/miss counters, wrapping modulo 2^32.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (count_hit) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (count_miss) begin
        miss_count_reg <= miss_count_reg + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_count_reg;
  assign MISS_COUNT = miss_count_reg;
`else
  logic unused_counts;

  assign unused_counts = count_hit ^ count_miss;
  assign HIT_COUNT     = '0;
  assign MISS_COUNT    = '0;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: stimulus pushes expected fetch words,
// a monitor pops them whenever the cache serves a fetch (enabled, not busy).
module tb_instruction_cache;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [31:0]   PC;
  logic          insReadEn;
  logic [31:0]   INSTRUCTION;
  logic          INS_CACHE_BUSY_WAIT;
  logic          MEM_READ;
  logic [27:0]   MEM_ADDR;
  logic [127:0]  MEM_READ_DATA;
  logic          MEM_BUSY_WAIT;
  logic [31:0]   HIT_COUNT;
  logic [31:0]   MISS_COUNT;

  int total = 0;
  int bad   = 0;
  int mem_lat = 3;
  int mem_cnt = 0;
  logic [31:0] exp_q[$];
  logic        prev_read = 1'b0;
  logic [27:0] prev_addr = '0;

`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 CLK = ~CLK;

  instruction_cache #(.INDEX_BITS(3)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .PC                  (PC),
    .insReadEn           (insReadEn),
    .INSTRUCTION         (INSTRUCTION),
    .INS_CACHE_BUSY_WAIT (INS_CACHE_BUSY_WAIT),
    .MEM_READ            (MEM_READ),
    .MEM_ADDR            (MEM_ADDR),
    .MEM_READ_DATA       (MEM_READ_DATA),
    .MEM_BUSY_WAIT       (MEM_BUSY_WAIT),
    .HIT_COUNT           (HIT_COUNT),
    .MISS_COUNT          (MISS_COUNT)
  );

  // Memory contents: block 0 is the program from the test plan, every other
  // block holds words {block_addr, word, 2'b11}.
  function automatic logic [127:0] mem_block(input logic [27:0] a);
    logic [127:0] blk;
    if (a == 28'h0) begin
      blk = 128'h00000013_00500093_00000013_00100093;
    end else begin
      for (int w = 0; w < 4; w++) begin
        blk[32*w +: 32] = {a, 2'(w), 2'b11};
      end
    end
    return blk;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end else begin
      $display("ok   %s: got=%h", name, act);
    end
  endtask

  // Memory model: data valid on the L-th MEM_READ cycle; while idle the
  // busy line sits low, which the cache must ignore.
  always @(negedge CLK) begin
    if (MEM_READ === 1'b1) begin
      if (mem_cnt >= mem_lat - 1) begin
        MEM_BUSY_WAIT = 1'b0;
        MEM_READ_DATA = mem_block(MEM_ADDR);
      end else begin
        MEM_BUSY_WAIT = 1'b1;
        MEM_READ_DATA = '0;
      end
      mem_cnt++;
    end else begin
      mem_cnt       = 0;
      MEM_BUSY_WAIT = 1'b0;
      MEM_READ_DATA = {4{32'hDEADBEEF}};
    end
  end

  // Monitor: compare every served fetch against the scoreboard, and check
  // that MEM_ADDR holds while a block read is outstanding.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && insReadEn === 1'b1 && INS_CACHE_BUSY_WAIT === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fetch: got=%h want=none", INSTRUCTION);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("fetch_word", INSTRUCTION, e);
      end
    end
    if (MEM_READ === 1'b1 && prev_read) begin
      check("mem_addr_stable", 32'(MEM_ADDR), 32'(prev_addr));
    end
    prev_read = (MEM_READ === 1'b1);
    prev_addr = MEM_ADDR;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_hit(input logic [31:0] pc, input logic [31:0] exp);
    PC        = pc;
    insReadEn = 1'b1;
    exp_q.push_back(exp);
    @(negedge CLK);
    check("hit_busy", 32'(INS_CACHE_BUSY_WAIT), 32'd0);
    step();
  endtask

  task automatic do_miss(input logic [31:0] pc, input logic [31:0] exp,
                         input logic [27:0] addr, input int lat);
    int n;
    mem_lat   = lat;
    PC        = pc;
    insReadEn = 1'b1;
    exp_q.push_back(exp);
    @(negedge CLK);
    check("miss_busy", 32'(INS_CACHE_BUSY_WAIT), 32'd1);
    check("miss_instr", INSTRUCTION, 32'd0);
    check("miss_no_read_yet", 32'(MEM_READ), 32'd0);
    n = 0;
    while (INS_CACHE_BUSY_WAIT !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        check("mem_read_high", 32'(MEM_READ), 32'd1);
        check("mem_addr", 32'(MEM_ADDR), 32'(addr));
      end
      if (n == lat + 1) begin
        check("mem_read_low_update", 32'(MEM_READ), 32'd0);
      end
    end
    check("miss_penalty", 32'(n), 32'(lat + 2));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET         = 1'b0;
    PC            = 32'h0;
    insReadEn     = 1'b1;
    MEM_BUSY_WAIT = 1'b0;
    MEM_READ_DATA = '0;
    step();
    step();

    // Reset state, with a fetch request present.
    @(negedge CLK);
    check("rst_busy", 32'(INS_CACHE_BUSY_WAIT), 32'd0);
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    check("rst_instr", INSTRUCTION, 32'd0);
    check("rst_hit_count", HIT_COUNT, 32'd0);
    check("rst_miss_count", MISS_COUNT, 32'd0);
    step();
    insReadEn = 1'b0;
    RESET     = 1'b1;
    step();

    // Cold miss on block 0, L = 3, then hits across the block.
    do_miss(32'h0, 32'h00100093, 28'h0, 3);
    do_hit(32'h4, 32'h00000013);
    do_hit(32'h8, 32'h00500093);
    do_hit(32'hC, 32'h00000013);
    insReadEn = 1'b0;
    check("hit_count", HIT_COUNT, PERF ? 32'd4 : 32'd0);
    check("miss_count", MISS_COUNT, PERF ? 32'd1 : 32'd0);

    // No request: quiet outputs, no memory traffic, even on a cached PC.
    PC = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) PC = 32'h4;
      @(negedge CLK);
      check("idle_busy", 32'(INS_CACHE_BUSY_WAIT), 32'd0);
      check("idle_mem_read", 32'(MEM_READ), 32'd0);
      check("idle_instr", INSTRUCTION, 32'd0);
      step();
    end

    // Byte offset bits are ignored.
    do_hit(32'h7, 32'h00000013);

    // Conflict on index 0, then block 0 must be refetched (L = 1 boundary).
    do_miss(32'h80, 32'h00000083, 28'h8, 2);
    do_hit(32'h84, 32'h00000087);
    do_miss(32'h0, 32'h00100093, 28'h0, 1);

    // Highest index line.
    do_miss(32'h70, 32'h00000073, 28'h7, 2);
    do_hit(32'h7C, 32'h0000007F);

    // Reset in the middle of a refill.
    mem_lat   = 10;
    PC        = 32'h40;
    insReadEn = 1'b1;
    @(negedge CLK);
    check("abort_detect_busy", 32'(INS_CACHE_BUSY_WAIT), 32'd1);
    step();
    @(negedge CLK);
    check("abort_mem_read", 32'(MEM_READ), 32'd1);
    step();
    RESET = 1'b0;
    step();
    @(negedge CLK);
    check("abort_mem_read_low", 32'(MEM_READ), 32'd0);
    check("abort_mem_addr", 32'(MEM_ADDR), 32'd0);
    check("abort_busy", 32'(INS_CACHE_BUSY_WAIT), 32'd0);
    check("abort_instr", INSTRUCTION, 32'd0);
    check("abort_hit_count", HIT_COUNT, 32'd0);
    check("abort_miss_count", MISS_COUNT, 32'd0);
    step();
    insReadEn = 1'b0;
    RESET     = 1'b1;
    step();

    // Valid bits were cleared: block 0 misses again.
    do_miss(32'h0, 32'h00100093, 28'h0, 1);
    insReadEn = 1'b0;
    check("post_rst_hit_count", HIT_COUNT, PERF ? 32'd1 : 32'd0);
    check("post_rst_miss_count", MISS_COUNT, PERF ? 32'd1 : 32'd0);
    step();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
